// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: default sizing and FSM encoding.
package mem_arb_pkg;

  localparam int DEF_NREQ    = 3;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sequencing one outstanding access at a time to an external
// memory controller: IDLE (accept) -> ISSUE (strobe) -> WAIT (done/timeout) -> RESP.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  // Handshake: a request is taken in the IDLE cycle where req_ready[i] pulses while
  // req_valid[i] is high; after that the requester's inputs are ignored until RESP,
  // which pulses rsp_valid[i] exactly once per accepted request.

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d, owner_q, owner_d;
  logic            we_q, we_d, err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (win_oh),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // Saturating so a long stall can never wrap back below TIMEOUT.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          owner_d = win_idx;
          we_d    = req_we[win_idx];
          addr_d  = req_addr[int'(win_idx)*AW +: AW];
          wdata_d = req_wdata[int'(win_idx)*DW +: DW];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // mem_done is checked first so it wins a same-cycle timeout.
        if (mem_done) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE && !reset) ? win_oh : '0;
  assign mem_read  = (state_q == ST_ISSUE) && !we_q;
  assign mem_write = (state_q == ST_ISSUE) && we_q;
  assign rsp_valid = (state_q == ST_RESP) ? (ONE << owner_q) : '0;
  assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
